// File: rtl/demux_capture_311.sv
// rtl/demux_capture_311.sv - four-channel rising-edge event counters behind the 1x4 demux
// Per-channel saturating counters with sticky overflow, read back through a req/ack port.
module demux_capture_311 #(
  parameter int CW        = 8,
  parameter bit CLR_ON_RD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          y0_311,
  input  logic          y1_311,
  input  logic          y2_311,
  input  logic          y3_311,
  input  logic          clr,
  input  logic          rd_req,
  input  logic [1:0]    rd_sel,
  input  logic          rd_ack,
  output logic [CW-1:0] data_311,
  output logic          valid_311,
  output logic          busy_311,
  output logic [3:0]    ovf_311
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state;
  logic [1:0]    sel_q;
  logic [3:0]    y_now;
  logic [3:0]    y_hist;
  logic [3:0]    rise;
  logic [3:0]    rd_clr;
  logic [CW-1:0] cnt [4];

  assign y_now = {y3_311, y2_311, y1_311, y0_311};
  assign rise  = y_now & ~y_hist;

  // Destructive read targets only the latched channel, and only during LOAD.
  always_comb begin
    rd_clr = 4'b0000;
    if (CLR_ON_RD && (state == LOAD)) begin
      rd_clr[sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_hist  <= 4'b0000;
      ovf_311 <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      y_hist <= y_now;
      for (int k = 0; k < 4; k++) begin
        if (clr) begin
          cnt[k]     <= '0;
          ovf_311[k] <= 1'b0;
        end else if (rd_clr[k]) begin
          // A rise landing in the read cycle is kept rather than lost.
          cnt[k]     <= rise[k] ? CW'(1) : '0;
          ovf_311[k] <= 1'b0;
        end else if (rise[k]) begin
          if (cnt[k] == CNT_MAX) begin
            ovf_311[k] <= 1'b1;
          end else begin
            cnt[k] <= cnt[k] + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 2'd0;
      data_311  <= '0;
      valid_311 <= 1'b0;
      busy_311  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_311 <= 1'b0;
          if (rd_req) begin
            sel_q    <= rd_sel;
            state    <= LOAD;
            busy_311 <= 1'b1;
          end
        end
        LOAD: begin
          data_311  <= cnt[sel_q];
          valid_311 <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rd_ack) begin
            valid_311 <= 1'b0;
            busy_311  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          valid_311 <= 1'b0;
          busy_311  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/demux_capture_311.md
# demux_capture_311

Four-channel event capture stage placed directly downstream of the 1x4 demultiplexer. It watches the demux outputs y0..y3 for rising edges, keeps a saturating event count per channel, and returns any channel's count through a request/acknowledge readout port. This makes the demux routing observable and checkable over many clock cycles, not just as an instantaneous combinational value.

## Interface
- CW, 8: width of each per-channel event counter and of the readout data.
- CLR_ON_RD, 1: 1 = the selected channel's counter and overflow flag clear when it is read; 0 = reads are non-destructive.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- y0_311, y1_311, y2_311, y3_311  input  1 each  demux outputs, synchronous to clk.
- clr  input  1  synchronous clear of all counters and overflow flags.
- rd_req  input  1  readout request, sampled only in IDLE.
- rd_sel  input  2  channel to read (0..3), sampled with rd_req.
- rd_ack  input  1  consumer acknowledge of the held data.
- data_311  output  CW  count of the selected channel.
- valid_311  output  1  data_311 is valid and held.
- busy_311  output  1  FSM not in IDLE.
- ovf_311  output  4  sticky per-channel saturation flags; bit k is channel k.

## Operation
- Reset (rst_n low, asynchronous): all counters 0, ovf_311=0, data_311=0, valid_311=0, busy_311=0, FSM to IDLE, edge history registers 0, latched select 0.
- Edge detect: a rise on channel k is y_k high while the registered history of y_k is 0. History resets to 0, so a channel already high when reset is released counts one event on the first clock.
- Count: each rise increments counter k by 1. At 2^CW-1 the counter holds its value, and a further rise sets ovf_311[k]. Channels count independently and can all increment in the same cycle.
- clr: all counters and ovf_311 go to 0. clr has priority over increments in the same cycle. clr does not affect the FSM, data_311 or valid_311.
- FSM states:
  - IDLE: valid_311=0. If rd_req=1, latch rd_sel and go to LOAD.
  - LOAD: data_311 takes the registered count of the latched channel as it stands before this cycle's edge. valid_311 goes to 1. If CLR_ON_RD=1, that counter and its ovf bit clear; a rise on that channel in the same cycle leaves the counter at 1. Go to HOLD.
  - HOLD: data_311 and valid_311 stay stable. When rd_ack=1, valid_311 drops on the next edge and the FSM returns to IDLE.
- rd_req outside IDLE is ignored, with no queuing. rd_ack outside HOLD is ignored.
- data_311 keeps its last value after valid_311 drops.
- busy_311 = (state != IDLE).

## Timing
- Counter and ovf update one cycle after the edge on y_k is sampled.
- Read latency: rd_req sampled at edge n, LOAD after edge n, valid_311 and data_311 updated at edge n+1.
- rd_ack sampled at edge m in HOLD gives valid_311=0 and IDLE after edge m. Earliest next request is sampled at edge m+1.
- Minimum read cycle is 3 clocks: request, load, ack in the first HOLD cycle.
- rst_n asserted mid-read (in LOAD or HOLD): the block drops to IDLE with every output at its reset value immediately, without waiting for a clock.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst_n low with y*=0 -> data_311=0, valid_311=0, busy_311=0, ovf_311=4'b0000. Release rst_n with y0=1 -> counter0=1 after the first edge.
- Demux sweep: with i=1, step s1s0 through 00,01,10,11, 5 cycles per setting, returning outputs low between settings; repeat 3 times. Read each channel -> data_311=3 for every channel, ovf_311=0.
- Saturation: apply 256 rises on y2 -> read gives data_311=255 and ovf_311[2]=1. With CLR_ON_RD=1, a second read gives 0 and ovf_311[2]=0.
- Clear-on-read collision: counter1=5 and a y1 rise arrives in the LOAD cycle -> data_311=5, counter1 ends at 1.
- Handshake: hold rd_ack=0 for 10 cycles in HOLD while issuing rd_req pulses -> valid_311 stays 1, data_311 is unchanged and no new read starts. rd_ack=1 -> valid_311=0 on the next edge.
- Async reset in HOLD: assert rst_n low between edges -> valid_311 and busy_311 fall immediately, and counters read 0 after release.
